// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: descriptor-driven row reader for the wide RAM read port, returning rows as a valid/ready stream.
// Latency: start_i in cycle 0 -> rd_en_o in cycle 1 -> FIFO push at end of cycle 2 -> valid_o in cycle 3; one row/cycle sustained.
// Backpressure: reads are throttled against FIFO occupancy plus reads in flight, so a stalled consumer never loses or duplicates a row.
//
// Ports:
//   clk, nrst                          clock, asynchronous active-low reset
//   start_i, base_addr_i, stride_i,    descriptor; latched only when idle
//   num_rows_i
//   busy_o, done_o                     transfer status; done_o pulses after the last row is handed off
//   rd_en_o, rd_addr_o, rd_data_i      RAM wide read port (registered request, data one cycle later)
//   data_o, valid_o, ready_i           output stream

// Small synchronous FIFO used as the output skid buffer.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the writer must guarantee it never pushes into a full FIFO.
//
// Ports:
//   i_push, i_dat    write side
//   i_pop            read side (consumes the head)
//   o_vld, o_dat     head entry; o_dat is zero when empty
//   o_count          current occupancy, 0..DEPTH
module ram_rd_streamer_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_dat,
  input  logic                       i_pop,
  output logic                       o_vld,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DEPTH):0]     o_count
);

  // DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_dat;
    end
  end

  assign o_vld   = (r_count != '0);
  assign o_dat   = o_vld ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

module ram_rd_streamer #(
  parameter int addrWidth      = 32,
  parameter int interfaceWidth = 256,
  parameter int countWidth     = 16,
  parameter int fifoDepth      = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      start_i,
  input  logic [addrWidth-1:0]      base_addr_i,
  input  logic [addrWidth-1:0]      stride_i,
  input  logic [countWidth-1:0]     num_rows_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rd_en_o,
  output logic [addrWidth-1:0]      rd_addr_o,
  input  logic [interfaceWidth-1:0] rd_data_i,
  output logic [interfaceWidth-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int FCW = $clog2(fifoDepth) + 1;
  // One extra bit so occupancy + two in-flight reads cannot overflow.
  localparam int OW  = $clog2(fifoDepth) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_en;
  logic [addrWidth-1:0]  r_rd_addr;
  logic [addrWidth-1:0]  r_next_addr;
  logic [addrWidth-1:0]  r_stride;
  logic [countWidth-1:0] r_issue_left;
  logic [countWidth-1:0] r_pop_left;
  // rd_en_o delayed by one cycle: rd_data_i carries a valid row this cycle.
  logic                  r_pend;

  logic                  w_pop;
  logic                  w_fifo_vld;
  logic [FCW-1:0]        w_fifo_count;
  logic [OW-1:0]         w_occ;
  logic                  w_room;
  logic                  w_issue;

  ram_rd_streamer_fifo #(
    .DW    (interfaceWidth),
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (r_pend),
    .i_dat   (rd_data_i),
    .i_pop   (w_pop),
    .o_vld   (w_fifo_vld),
    .o_dat   (data_o),
    .o_count (w_fifo_count)
  );

  assign valid_o = w_fifo_vld;
  assign w_pop   = w_fifo_vld & ready_i;

  // Every read already committed (stage A or B) owns a FIFO slot, because the
  // RAM cannot be stalled once a read is issued. A pop this cycle frees one.
  assign w_occ   = OW'(w_fifo_count) + OW'(r_rd_en) + OW'(r_pend);
  assign w_room  = (w_occ < (OW'(fifoDepth) + OW'(w_pop)));
  assign w_issue = (r_state == RUN) && (r_issue_left != '0) && w_room;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_next_addr  <= '0;
      r_stride     <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
      r_pend       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_pend  <= r_rd_en;

      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (num_rows_i != '0) begin
              // Row 0 is issued straight from the descriptor; the FIFO is
              // always empty in IDLE, so no room check is needed.
              r_state      <= RUN;
              r_busy       <= 1'b1;
              r_rd_en      <= 1'b1;
              r_rd_addr    <= base_addr_i;
              r_next_addr  <= base_addr_i + stride_i;
              r_stride     <= stride_i;
              r_issue_left <= num_rows_i - countWidth'(1);
              r_pop_left   <= num_rows_i;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (w_issue) begin
            r_rd_en      <= 1'b1;
            r_rd_addr    <= r_next_addr;
            // Incremental address; wraps modulo 2^addrWidth.
            r_next_addr  <= r_next_addr + r_stride;
            r_issue_left <= r_issue_left - countWidth'(1);
          end
          if ((r_issue_left == '0) ||
              (w_issue && (r_issue_left == countWidth'(1)))) begin
            r_state <= DRAIN;
          end
        end

        DRAIN: begin
          if (w_pop && (r_pop_left == countWidth'(1))) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Count handoffs; the final one is always seen in DRAIN because the
      // last read leaves RUN at least two cycles before its data can pop.
      if (w_pop && (r_state != IDLE)) begin
        r_pop_left <= r_pop_left - countWidth'(1);
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rd_addr;

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Testbench for ram_rd_streamer: directed descriptors against a registered-read RAM model.
module tb_ram_rd_streamer;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_i = 1'b0;
  logic [31:0]  base_addr_i = '0;
  logic [31:0]  stride_i = '0;
  logic [15:0]  num_rows_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         rd_en_o;
  logic [31:0]  rd_addr_o;
  logic [255:0] rd_data_i = '0;
  logic [255:0] data_o;
  logic         valid_o;
  logic         ready_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_rd_streamer dut (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .num_rows_i  (num_rows_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  // RAM contents: every lane derived differently from the address.
  function automatic logic [255:0] row_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, a + 32'd7, {a[15:0], a[31:16]},
            ~a ^ 32'h0000_00FF, a - 32'd3, 32'hCAFE_F00D};
  endfunction

  // Single-cycle registered read port.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= row_of(rd_addr_o);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] stride, input int num);
    base_addr_i = base;
    stride_i    = stride;
    num_rows_i  = 16'(num);
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready 0 for 10 cycles then 1; mode 2: random ready.
  task automatic run_xfer(input string nm, input logic [31:0] base, input logic [31:0] stride,
                          input int num, input int mode, input bit restart);
    int issued = 0;
    int popped = 0;
    int max_out = 0;
    int issued_stall = 0;
    bit fin = 1'b0;
    bit prev_stall = 1'b0;
    logic [255:0] prev_dat = '0;
    logic [31:0] a;
    start_xfer(base, stride, num);
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (cyc > 10);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      if (restart && cyc == 5) begin
        start_i     = 1'b1;
        base_addr_i = 32'hDEAD_0000;
        num_rows_i  = 16'd3;
      end else begin
        start_i = 1'b0;
      end
      if (cyc == 1) chk({nm, "_busy_on"}, 256'(busy_o), 256'(1));
      if (rd_en_o) begin
        a = base + stride * 32'(issued);
        chk({nm, "_addr"}, 256'(rd_addr_o), 256'(a));
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (mode == 1 && cyc == 10) issued_stall = issued;
      if (prev_stall) begin
        chk({nm, "_hold_vld"}, 256'(valid_o), 256'(1));
        chk({nm, "_hold_dat"}, data_o, prev_dat);
      end
      prev_stall = valid_o && !ready_i;
      prev_dat   = data_o;
      if (valid_o && ready_i) begin
        a = base + stride * 32'(popped);
        chk({nm, "_data"}, data_o, row_of(a));
        popped++;
      end
      if (done_o) begin
        fin = 1'b1;
        chk({nm, "_busy_off"}, 256'(busy_o), 256'(0));
      end
      tick();
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    chk({nm, "_finished"}, 256'(fin), 256'(1));
    chk({nm, "_issued"}, 256'(issued), 256'(num));
    chk({nm, "_popped"}, 256'(popped), 256'(num));
    chk({nm, "_occ_over4"}, 256'(max_out > 4), 256'(0));
    if (mode == 1) chk({nm, "_stall_reads"}, 256'(issued_stall), 256'(4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    chk("rst_busy",  256'(busy_o),    256'(0));
    chk("rst_done",  256'(done_o),    256'(0));
    chk("rst_rden",  256'(rd_en_o),   256'(0));
    chk("rst_addr",  256'(rd_addr_o), 256'(0));
    chk("rst_valid", 256'(valid_o),   256'(0));
    chk("rst_data",  data_o,          256'(0));
    tick();
    nrst = 1'b1;
    tick();

    // Basic transfer with exact cycle timing.
    ready_i = 1'b1;
    start_xfer(32'h100, 32'h20, 4);
    for (int c = 1; c <= 8; c++) begin
      chk("b_rden", 256'(rd_en_o), 256'(c <= 4));
      if (c <= 4) chk("b_addr", 256'(rd_addr_o), 256'(32'h100 + 32'(c - 1) * 32'h20));
      chk("b_valid", 256'(valid_o), 256'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("b_data", data_o, row_of(32'h100 + 32'(c - 3) * 32'h20));
      chk("b_done", 256'(done_o), 256'(c == 7));
      chk("b_busy", 256'(busy_o), 256'(c <= 6));
      tick();
    end

    // Zero rows: done next cycle, no reads, never busy.
    start_xfer(32'h300, 32'h20, 0);
    for (int c = 1; c <= 3; c++) begin
      chk("z_done", 256'(done_o),  256'(c == 1));
      chk("z_busy", 256'(busy_o),  256'(0));
      chk("z_rden", 256'(rd_en_o), 256'(0));
      tick();
    end

    run_xfer("bp",   32'h1000,      32'h40, 8,  1, 1'b0);
    run_xfer("rnd",  32'h2000,      32'h20, 32, 2, 1'b0);
    run_xfer("rst",  32'h0200,      32'h20, 8,  0, 1'b1);
    run_xfer("wrap", 32'hFFFF_FFE0, 32'h20, 2,  0, 1'b0);

    // Reset with two reads in flight.
    ready_i = 1'b0;
    start_xfer(32'h400, 32'h20, 8);
    tick();
    chk("ar_inflight", 256'(rd_en_o), 256'(1));
    #2 nrst = 1'b0;
    #1;
    chk("ar_busy",  256'(busy_o),    256'(0));
    chk("ar_done",  256'(done_o),    256'(0));
    chk("ar_rden",  256'(rd_en_o),   256'(0));
    chk("ar_addr",  256'(rd_addr_o), 256'(0));
    chk("ar_valid", 256'(valid_o),   256'(0));
    chk("ar_data",  data_o,          256'(0));
    tick();
    nrst    = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("ar_stale_valid", 256'(valid_o), 256'(0));
      chk("ar_stale_done",  256'(done_o),  256'(0));
      tick();
    end
    run_xfer("post", 32'h500, 32'h20, 3, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read initiator for the wide read port of the shared 2W2R activation/weight RAM.
- Accepts a descriptor: base address, stride and row count.
- Issues one wide read per row against the RAM's single-cycle registered read.
- Returns the rows as a valid/ready stream, with a small FIFO absorbing consumer backpressure so no read is lost or duplicated.

Parameters:
addrWidth, 32, width of RAM address and stride
interfaceWidth, 256, width of one row (RAM wide read port)
countWidth, 16, width of row counter / num_rows_i
fifoDepth, 4, output FIFO entries; power of 2, >= 3 required for full throughput

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse: latch descriptor and begin
base_addr_i  input  addrWidth  address of row 0
stride_i  input  addrWidth  address increment between rows
num_rows_i  input  countWidth  rows to fetch; 0 allowed
busy_o  output  1  transfer in progress
done_o  output  1  one-cycle pulse when the last row is handed off
rd_en_o  output  1  RAM read enable (registered)
rd_addr_o  output  addrWidth  RAM read address (registered)
rd_data_i  input  interfaceWidth  RAM read data, valid the cycle after rd_en_o
data_o  output  interfaceWidth  stream data (FIFO head)
valid_o  output  1  stream valid (FIFO not empty)
ready_i  input  1  stream ready from consumer

Behaviour:
- Reset: busy_o, done_o, rd_en_o, valid_o = 0; rd_addr_o = 0; data_o = 0; FIFO emptied; counters and pipeline flags cleared.
- FSM states IDLE, RUN, DRAIN.
- IDLE:
  - start_i latches descriptor.
  - num_rows_i > 0 -> RUN, busy_o = 1 from next cycle.
  - num_rows_i == 0 -> done_o pulses next cycle, busy_o stays 0, no reads issued.
- start_i while busy_o = 1 is ignored; the descriptor is not re-latched.
- Read pipeline:
  - Stage A = rd_en_o high (RAM samples at end of cycle).
  - Stage B = pend, i.e. rd_en_o delayed one cycle; rd_data_i valid this cycle.
  - Data is pushed into the FIFO at the end of a cycle where pend = 1.
- Issue rule: rd_en_o asserted for next cycle iff in RUN, rows remain to issue, and fifo_count + rd_en_o + pend - pop < fifoDepth, where pop = valid_o & ready_i.
  - Guarantees the FIFO never overflows, since the RAM does not stall.
- Address generation:
  - Row k address = base + k*stride, computed incrementally.
  - Wraps modulo 2^addrWidth; no error.
  - rd_addr_o holds its last value when rd_en_o = 0.
- Throughput: with ready_i held 1, one row per cycle after start-up latency.
  - start_i at cycle 0 -> rd_en_o cycle 1 -> push end of cycle 2 -> valid_o cycle 3.
- Stream rules:
  - data_o is stable while valid_o & !ready_i.
  - Rows appear in issue order.
  - rd_data_i is passed unmodified; no byte reordering.
- RUN -> DRAIN when the last read is issued. DRAIN -> IDLE on the handoff (pop) of the last row.
  - done_o pulses in the cycle after that pop; busy_o falls in the same cycle.
- Simultaneous push and pop: both take effect; fifo_count unchanged. A pop from an empty FIFO is impossible (valid_o = 0).
- Reset mid-operation: abort immediately to IDLE. Outstanding reads are discarded, FIFO is emptied, no done_o.

Test Plan:
- Basic transfer: base 0x100, stride 0x20, num 4, ready_i = 1.
  -> rd_addr_o 0x100, 0x120, 0x140, 0x160 on cycles 1-4.
  -> valid_o cycles 3-6 with RAM contents in order.
  -> done_o on cycle 7; busy_o cycles 1-6.
- Backpressure: num 8, ready_i = 0 for 10 cycles then 1.
  -> at most 4 reads issued before stall.
  -> all 8 rows delivered in order, no duplicates; data_o stable while stalled.
- Random ready_i (50%), num 32, stride 0x20.
  -> scoreboard matches 32 rows exactly; FIFO never exceeds 4.
- num 0 -> rd_en_o never asserted, done_o pulses cycle 1, busy_o stays 0.
- Restart and wrap: start_i pulsed again mid-transfer -> ignored.
  - Separately, base 0xFFFFFFE0, stride 0x20, num 2 -> addresses 0xFFFFFFE0, 0x00000000.
- Reset: nrst asserted during RUN with 2 reads in flight.
  -> all outputs 0 asynchronously; no stale valid_o after release; next start works normally.
